mul_share_seq: RTL and testbench

- Sequential sign-magnitude 3-bit multiplier shared by two requesters under round-robin arbitration.
- Operand format: bit 2 = sign (1 = negative), bits 1:0 = magnitude.
- Result format: 5 bits. Bit 4 = sign, bits 3:0 = magnitude, plus a zero flag.
- Sits between the calculator's operation decoders and the result bus. Replaces combinational multiply where shift-add sequencing and sharing are needed.

---
 rtl/mul_share_seq.sv | 132 +++++++++++++
 tb/tb_mul_share_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_seq.sv
// Sequential sign-magnitude 3-bit multiplier shared by two requesters under round-robin arbitration.
// Optional macro MUL_EARLY_TERM_EN: a zero-magnitude operand skips the shift-add iterations.
module mul_share_seq #(
  parameter int ITER = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic [2:0] i_A0,
  input  logic [2:0] i_B0,
  input  logic [2:0] i_A1,
  input  logic [2:0] i_B1,
  output logic [1:0] o_gnt,
  output logic       o_busy,
  output logic       o_valid,
  input  logic       i_res_ready,
  output logic [4:0] o_res,
  output logic       o_Z,
  output logic       o_id
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: a request is held until o_gnt pulses for it in IDLE; a result
  // is offered while o_valid is high and retires on the edge where i_res_ready is 1.

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_a_mag;
  logic [1:0]      r_b_mag;
  logic            r_sign;
  logic [3:0]      r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_last;
  logic            r_id;

  logic            w_sel;
  logic            w_take;
  logic [1:0]      w_gnt;
  logic [2:0]      w_a;
  logic [2:0]      w_b;
  logic            w_early;
  logic [3:0]      w_addend;

  always_comb begin
    w_sel  = (i_req == 2'b11) ? ~r_last : i_req[1];
    w_take = (r_state == S_IDLE) && (i_req != 2'b00);
    w_gnt  = 2'b00;
    if (w_take) begin
      w_gnt = w_sel ? 2'b10 : 2'b01;
    end
    w_a      = w_sel ? i_A1 : i_A0;
    w_b      = w_sel ? i_B1 : i_B0;
    w_addend = {2'b00, r_a_mag} << r_cnt;
  end

`ifdef MUL_EARLY_TERM_EN
  assign w_early = (w_a[1:0] == 2'b00) || (w_b[1:0] == 2'b00);
`else
  assign w_early = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_state_nxt = w_early ? S_DONE : S_MUL;
        end
      end
      S_MUL: begin
        if (r_cnt == CW'(ITER - 1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands are only sampled on the grant edge; a pending requester's inputs are ignored while busy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_mag <= 2'b00;
      r_b_mag <= 2'b00;
      r_sign  <= 1'b0;
      r_acc   <= 4'd0;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
    end else if (w_take) begin
      r_a_mag <= w_a[1:0];
      r_b_mag <= w_b[1:0];
      r_sign  <= w_a[2] ^ w_b[2];
      r_acc   <= 4'd0;
      r_cnt   <= '0;
      r_last  <= w_sel;
      r_id    <= w_sel;
    end else if (r_state == S_MUL) begin
      if (r_b_mag[r_cnt]) begin
        r_acc <= r_acc + w_addend;
      end
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_gnt   = w_gnt;
  assign o_busy  = (r_state != S_IDLE);
  assign o_valid = (r_state == S_DONE);
  assign o_res   = {r_sign, r_acc};
  assign o_Z     = (r_acc == 4'd0);
  assign o_id    = r_id;

endmodule

// File: tb/tb_mul_share_seq.sv
// Self-checking bench for mul_share_seq: arbitration model, product scoreboard, backpressure and reset.
// Honours MUL_EARLY_TERM_EN for the expected result latency.
module tb_mul_share_seq;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [1:0] tb_req;
  logic [2:0] a0, b0, a1, b1;
  logic [1:0] o_gnt;
  logic       o_busy, o_valid, o_Z, o_id;
  logic       res_ready;
  logic [4:0] o_res;

  assign tb_req = {req1, req0};

  mul_share_seq dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(tb_req),
    .i_A0(a0), .i_B0(b0), .i_A1(a1), .i_B1(b1),
    .o_gnt(o_gnt), .o_busy(o_busy), .o_valid(o_valid),
    .i_res_ready(res_ready), .o_res(o_res), .o_Z(o_Z), .o_id(o_id)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Scoreboard entry: {id, sign, mag[3:0], zero}
  logic [6:0] exp_q[$];
  logic       m_busy = 1'b0;
  logic       m_last = 1'b1;
  int         m_valid_at = 0;

  logic       rdy_mode  = 1'b0;
  logic       rdy_fixed = 1'b1;

  always @(posedge clk) begin
    #1;
    res_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int   idx;
      int   exp_gnt;
      int   ma, mb, prod, lat;
      logic sg;
      logic accepted;
      exp_gnt = 0;
      idx = 0;
      if (!m_busy && tb_req != 2'b00) begin
        idx = (tb_req == 2'b11) ? int'(!m_last) : (tb_req[1] ? 1 : 0);
        exp_gnt = (idx == 1) ? 2 : 1;
      end
      chk("gnt", int'(o_gnt), exp_gnt);
      chk("busy", int'(o_busy), int'(m_busy));
      chk("valid", int'(o_valid), int'(m_busy && cyc >= m_valid_at));
      accepted = 1'b0;
      if (o_valid && exp_q.size() > 0) begin
        chk("res", int'(o_res), int'(exp_q[0][5:1]));
        chk("z", int'(o_Z), int'(exp_q[0][0]));
        chk("id", int'(o_id), int'(exp_q[0][6]));
        if (res_ready) begin
          void'(exp_q.pop_front());
          accepted = 1'b1;
        end
      end
      if (exp_gnt != 0) begin
        ma   = (idx == 1) ? int'(a1[1:0]) : int'(a0[1:0]);
        mb   = (idx == 1) ? int'(b1[1:0]) : int'(b0[1:0]);
        sg   = (idx == 1) ? (a1[2] ^ b1[2]) : (a0[2] ^ b0[2]);
        prod = ma * mb;
        lat  = 3;
`ifdef MUL_EARLY_TERM_EN
        if (ma == 0 || mb == 0) lat = 1;
`endif
        exp_q.push_back({1'(idx), sg, 4'(prod), (prod == 0)});
        m_busy     = 1'b1;
        m_valid_at = cyc + lat;
        m_last     = 1'(idx);
      end else if (accepted) begin
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int idx, input logic [2:0] a, input logic [2:0] b);
    bit got;
    got = 1'b0;
    if (idx == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
    else          begin a1 = a; b1 = b; req1 = 1'b1; end
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (o_gnt[idx]) got = 1'b1;
    end
    @(posedge clk);
    #1;
    if (idx == 0) req0 = 1'b0; else req1 = 1'b0;
    if (!got) chk("grant_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int k;
    k = 0;
    while ((exp_q.size() > 0 || m_busy) && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (k >= 400) chk("drain_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    res_ready = 1'b1;
    #2;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_gnt", int'(o_gnt), 0);
    chk("rst_res", int'(o_res), 0);
    chk("rst_z", int'(o_Z), 1);
    chk("rst_id", int'(o_id), 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    idle_cycles(1);

    // basic multiply and signed zero
    issue(0, 3'b011, 3'b111);
    drain();
    issue(0, 3'b100, 3'b010);
    drain();

    // contention: both held continuously
    fork
      begin
        for (int i = 0; i < 3; i++) issue(0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
      begin
        for (int i = 0; i < 3; i++) issue(1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
    join
    drain();

    // backpressure with a pending request
    rdy_fixed = 1'b0;
    issue(0, 3'b110, 3'b011);
    begin
      int k;
      k = 0;
      while (!o_valid && k < 50) begin @(posedge clk); #1; k++; end
      if (k >= 50) chk("bp_valid_timeout", 0, 1);
    end
    fork
      issue(1, 3'b101, 3'b110);
      begin
        repeat (5) @(posedge clk);
        rdy_fixed = 1'b1;
      end
    join
    drain();

    // reset during MUL
    issue(1, 3'b111, 3'b011);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_res", int'(o_res), 0);
    chk("mid_rst_z", int'(o_Z), 1);
    chk("mid_rst_id", int'(o_id), 0);
    exp_q.delete();
    m_busy = 1'b0;
    m_last = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle_cycles(6);
    issue(0, 3'b010, 3'b011);
    drain();

    // exhaustive sweep through requester 1 with random backpressure
    rdy_mode = 1'b1;
    for (int i = 0; i < 64; i++) begin
      issue(1, 3'(i >> 3), 3'(i & 7));
    end
    drain();

    // random concurrent traffic
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          idle_cycles($urandom_range(0, 3));
          issue(0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          idle_cycles($urandom_range(0, 3));
          issue(1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
      end
    join
    rdy_mode = 1'b0;
    rdy_fixed = 1'b1;
    drain();
    idle_cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
